// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand resolution: N-stage priority bypass plus per-register latency scoreboard.
// Combinational stall/operands; stall is the sole flow control.
module id_fwd_scoreboard #(
  parameter  int REG_AW     = 5,
  parameter  int DATA_W     = 32,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_STAGES = 2,
  parameter  int MAX_LAT    = 8,
  localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_en,
  input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
  input  logic [DATA_W-1:0]            imm,
  input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
  input  logic                         dst_en,
  input  logic [REG_AW-1:0]            dst_addr,
  input  logic [LAT_W-1:0]             dst_lat,
  input  logic [FWD_STAGES-1:0]        fwd_en,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  output logic [NUM_SRC*DATA_W-1:0]    opr_data,
  output logic                         stall,
  output logic [31:0]                  stall_cnt
);

  localparam int NREG = 1 << REG_AW;

  logic [LAT_W-1:0]          r_busy [NREG];
  logic [31:0]               r_stall_cnt;

  logic [NUM_SRC-1:0]        w_raw;
  logic                      w_waw;
  logic                      w_stall;
  logic                      w_accept;
  logic                      w_set;
  logic [LAT_W-1:0]          w_set_lat;
  logic [NUM_SRC*DATA_W-1:0] w_opr;

  // RAW looks at the pre-update busy value, so r5 <- r5 checks the old producer.
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_raw[i] = src_en[i] &&
                 (src_addr[i*REG_AW +: REG_AW] != '0) &&
                 (r_busy[src_addr[i*REG_AW +: REG_AW]] != '0);
    end
  end

  assign w_waw     = dst_en && (dst_addr != '0) && (r_busy[dst_addr] > dst_lat);
  assign w_stall   = !rst && issue_valid && !flush && ((|w_raw) || w_waw);
  assign w_accept  = issue_valid && !flush && !w_stall;
  assign w_set_lat = (dst_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : dst_lat;
  assign w_set     = w_accept && dst_en && (dst_addr != '0) && (dst_lat != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_busy[r] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      r_busy[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (r_busy[r] != '0) begin
          r_busy[r] <= r_busy[r] - LAT_W'(1);
        end
      end
      // A fresh issue overrides the decrement of its destination.
      if (w_set) begin
        r_busy[dst_addr] <= w_set_lat;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  // Later assignments win: imm > zero reg > youngest bypass > regfile.
  always_comb begin
    w_opr = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        w_opr[i*DATA_W +: DATA_W] = rf_data[i*DATA_W +: DATA_W];
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
          if (fwd_en[k] && (fwd_addr[k*REG_AW +: REG_AW] != '0) &&
              (fwd_addr[k*REG_AW +: REG_AW] == src_addr[i*REG_AW +: REG_AW])) begin
            w_opr[i*DATA_W +: DATA_W] = fwd_data[k*DATA_W +: DATA_W];
          end
        end
        if (src_addr[i*REG_AW +: REG_AW] == '0) begin
          w_opr[i*DATA_W +: DATA_W] = '0;
        end
        if (!src_en[i]) begin
          w_opr[i*DATA_W +: DATA_W] = imm;
        end
      end
    end
  end

  assign stall       = w_stall;
  assign issue_ready = !w_stall;
  assign opr_data    = w_opr;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: doc/id_fwd_scoreboard.md
Name: id_fwd_scoreboard

Overview:
- Parametrised operand-resolution and hazard block for the ID stage of the MIPS pipeline.
- Replaces the fixed two-stage (EX/MEM) bypass with an N-stage priority bypass network.
- Adds a per-register latency scoreboard so load-use and multi-cycle results (load, mult/div) raise an issue stall instead of forwarding stale data.
- Sits between decode/regfile read and the ID/EX pipeline register; drives the pipeline stall line.

Parameters:
- REG_AW, 5, register address width (2**REG_AW architectural registers; register 0 hard-wired to zero)
- DATA_W, 32, operand/data width
- NUM_SRC, 2, source operands per instruction
- FWD_STAGES, 2, bypass sources; index 0 = youngest (EX), increasing = older
- MAX_LAT, 8, maximum result latency tracked; LAT_W = $clog2(MAX_LAT+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  decoded instruction present in ID
- issue_ready  out  1  instruction accepted this cycle (= !stall)
- flush  in  1  kill the instruction currently in ID
- src_en  in  NUM_SRC  source i reads the register file
- src_addr  in  NUM_SRC*REG_AW  source register addresses
- imm  in  DATA_W  immediate, substituted for any source with src_en=0
- rf_data  in  NUM_SRC*DATA_W  register-file read data per source
- dst_en  in  1  instruction writes a register
- dst_addr  in  REG_AW  destination register
- dst_lat  in  LAT_W  extra cycles before result is bypassable (0=ALU, 1=load, n=multi-cycle)
- fwd_en  in  FWD_STAGES  bypass stage k holds a valid write
- fwd_addr  in  FWD_STAGES*REG_AW  bypass write addresses
- fwd_data  in  FWD_STAGES*DATA_W  bypass write data
- opr_data  out  NUM_SRC*DATA_W  resolved operands
- stall  out  1  hold IF/ID, inject bubble into EX
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- State:
  - busy[r] (LAT_W bits) for r = 1..2**REG_AW-1.
  - stall_cnt register.
  - busy[0] is constant 0.
- Reset (rst=1 at a clock edge):
  - All busy cleared; stall_cnt = 0.
  - While rst is high: stall=0, issue_ready=1, opr_data=0.
- Hazards (combinational):
  - RAW on source i: src_en[i] && src_addr[i]!=0 && busy[src_addr[i]]!=0.
  - WAW: dst_en && dst_addr!=0 && busy[dst_addr] > dst_lat.
- stall = issue_valid && !flush && (any RAW || WAW).
- accept = issue_valid && !flush && !stall.
- Scoreboard update each clock (non-reset):
  - Every nonzero busy[r] decrements by 1.
  - Then, if accept && dst_en && dst_addr!=0 && dst_lat!=0, busy[dst_addr] is set to min(dst_lat, MAX_LAT). This overrides the decrement for that register.
  - dst_lat=0 leaves busy untouched, so a dependent instruction in the next cycle forwards from stage 0.
  - Scoreboard timing: an instruction accepted at cycle t with lat L releases dependents at cycle t+L+1.
- Operand mux per source i (combinational, priority order):
  1. src_en=0 -> imm.
  2. src_addr=0 -> 0.
  3. Lowest k with fwd_en[k] && fwd_addr[k]==src_addr -> fwd_data[k].
  4. Otherwise rf_data[i].
  - fwd_addr=0 never matches.
- opr_data is driven even while stall=1; downstream ignores it because the bubble is inserted.
- flush:
  - Forces stall=0 and blocks any scoreboard set.
  - In-flight busy counters keep decrementing.
- stall_cnt: increments on every cycle with stall=1; holds at 0xFFFF_FFFF.
- Simultaneous events:
  - Dependent source on the same register the instruction writes (e.g. r5 <- r5) uses the old busy value for RAW, then sets the new busy.
  - rst has priority over flush and issue.
- dst_lat > MAX_LAT is clamped to MAX_LAT.
- No backpressure from EX; stall is the only flow control.

Test Plan:
- ALU chain: accept dst=r3 lat=0; next cycle src0=r3, fwd_en[0]=1, fwd_addr[0]=3, fwd_data[0]=0xDEADBEEF -> stall=0, opr0=0xDEADBEEF, stall_cnt=0.
- Load-use: accept dst=r5 lat=1; next cycle src1=r5 -> stall=1 for exactly 1 cycle, then issue_ready=1; stall_cnt=1.
- Multi-cycle with independent op:
  - Accept dst=r8 lat=4.
  - Dependent src=r8 -> stall 4 cycles.
  - Independent src=r9 issued at the same point as that dependent -> no stall; r9's operand resolves normally.
- Bypass priority:
  - Stage0 addr7 data 0x1 and stage1 addr7 data 0x2 -> opr=0x1.
  - src_addr=0 with fwd_addr=0, data 0x55 -> opr=0.
  - src_en=0, imm=0x0000_00FF -> opr=0xFF.
- WAW and flush:
  - r10 lat=5 in flight; new dst=r10 lat=0 -> stall until busy[r10]=0.
  - Same hazard with flush=1 -> stall=0, busy[r10] not reloaded.
- Reset mid-operation: busy[r4]=3, assert rst 1 cycle -> all busy=0, dependent on r4 issues with stall=0, stall_cnt=0.
